sync_down_counter: RTL and testbench

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

---
 rtl/sync_down_counter_pkg.sv | 28 ++
 rtl/sync_down_counter_jk_ff.sv | 42 ++++
 rtl/sync_down_counter.sv | 188 ++++++++++++++++++
 tb/tb_sync_down_counter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_down_counter_pkg
// Brief    : Shared types and constants for the sync_down_counter block:
//            FSM state encoding, counter-bit operation select, default width.
// Revision : 1.0 - initial release
// ============================================================================
package sync_down_counter_pkg;

  // Default counter width in bits
  localparam int DEFAULT_WIDTH = 4;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // What the JK bit array does on the next edge
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,  // J=K=0 on every bit
    CNT_LOAD = 2'b01,  // J=value, K=~value: parallel load
    CNT_DEC  = 2'b10   // J=K=toggle enable: decrement by one
  } cnt_op_e;

endpackage : sync_down_counter_pkg
`default_nettype wire

// File: rtl/sync_down_counter_jk_ff.sv
`default_nettype none
// ============================================================================
// Module   : jk_ff_ar
// Brief    : JK flip-flop with asynchronous active-low reset. J/K = 00 hold,
//            01 reset, 10 set, 11 toggle.
// Revision : 1.0 - initial release
// ============================================================================
module jk_ff_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Next-state decode of the JK truth table
  always_comb begin
    q_d = q_q;
    case ({j_i, k_i})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Storage element, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : jk_ff_ar
`default_nettype wire

// File: rtl/sync_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_down_counter
// Brief    : Loadable synchronous down counter with IDLE/COUNT/DONE control,
//            one-cycle done pulse on terminal count and combinational tc.
//            Count bits are JK flip-flops sharing one clock; toggle enables
//            come from the lower bits (synchronous, no ripple clocking).
// Options  : SYNC_DOWN_COUNTER_AUTORELOAD_EN - when defined, reload_en at
//            terminal count reloads the latched start value and keeps
//            counting. When undefined, reload_en is accepted but ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             clear,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_e           state_q;
  state_e           state_d;
  logic             done_q;
  logic             done_d;
  cnt_op_e          op_d;
  logic [WIDTH-1:0] load_sel_d;
  logic [WIDTH-1:0] count_q;
  logic             reload_go;
  logic [WIDTH-1:0] reload_val;
  logic             launch;

  // A start that actually launches a count (captures the reload value)
  assign launch = start && !clear && (state_q != COUNT) && (load_val != '0);

`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  // Reload value follows the most recent launching start
  always_comb begin
    reload_d = reload_q;
    if (launch) begin
      reload_d = load_val;
    end
  end

  // Reload register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  assign reload_go  = reload_en;
  assign reload_val = reload_q;
`else
  logic unused_reload_inputs;

  assign unused_reload_inputs = reload_en ^ launch;
  assign reload_go            = 1'b0;
  assign reload_val           = '0;
`endif

  // Next-state, done pulse and counter operation select
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    op_d       = CNT_HOLD;
    load_sel_d = '0;
    if (clear) begin
      // Abort wins over everything; count is forced to zero
      state_d = IDLE;
      op_d    = CNT_LOAD;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            op_d       = CNT_LOAD;
            load_sel_d = load_val;
            if (load_val != '0) begin
              state_d = COUNT;
            end else begin
              // Zero start is an immediate terminal event
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        COUNT: begin
          if (en) begin
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (reload_go) begin
                op_d       = CNT_LOAD;
                load_sel_d = reload_val;
              end else begin
                op_d    = CNT_DEC;
                state_d = DONE;
              end
            end else if (count_q != '0) begin
              op_d = CNT_DEC;
            end else begin
              // Never decrement through zero
              state_d = DONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          op_d    = CNT_LOAD;
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Counter bit slices: each bit toggles on decrement when all lower bits are 0
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic tog_b;
      logic j_b;
      logic k_b;

      if (i == 0) begin : g_lsb
        assign tog_b = 1'b1;
      end else begin : g_upper
        assign tog_b = ~|count_q[i-1:0];
      end

      // Map the selected operation onto this bit's J/K inputs
      always_comb begin
        j_b = 1'b0;
        k_b = 1'b0;
        case (op_d)
          CNT_LOAD: begin
            j_b = load_sel_d[i];
            k_b = ~load_sel_d[i];
          end
          CNT_DEC: begin
            j_b = tog_b;
            k_b = tog_b;
          end
          default: begin
            j_b = 1'b0;
            k_b = 1'b0;
          end
        endcase
      end

      jk_ff_ar u_jk (
        .clk   (clk),
        .rst_n (rst_n),
        .j_i   (j_b),
        .k_i   (k_b),
        .q_o   (count_q[i])
      );
    end
  endgenerate

  assign count = count_q;
  assign busy  = (state_q == COUNT);
  assign done  = done_q;
  assign tc    = (count_q == '0);

endmodule : sync_down_counter
`default_nettype wire

// File: tb/tb_sync_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_down_counter
// Brief    : Scoreboard bench for sync_down_counter (WIDTH=4). A behavioural
//            model predicts each edge; predictions are queued and compared
//            after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] load_val;
  logic         en;
  logic         clear;
  logic         reload_en;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tc;

  typedef struct {
    int cnt;
    int busy;
    int done;
    int tc;
  } exp_t;

  exp_t  sb[$];
  int    n_checks;
  int    n_fail;
  int    done_seen;
  string phase;

  // Model state: 0 idle, 1 count, 2 done
  int m_st;
  int m_cnt;
  int m_rl;
  int m_done;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_val  (load_val),
    .en        (en),
    .clear     (clear),
    .reload_en (reload_en),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tc        (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0d exp=%0d", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_rl = 0; m_done = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (clear) begin
      m_st = 0; m_cnt = 0;
    end else if (m_st != 1) begin
      if (start) begin
        if (load_val != 0) begin
          m_cnt = int'(load_val); m_rl = int'(load_val); m_st = 1;
        end else begin
          m_cnt = 0; m_done = 1; m_st = 2;
        end
      end
    end else if (en) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_done = 1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
        if (reload_en) m_cnt = m_rl;
        else begin m_cnt = 0; m_st = 2; end
`else
        m_cnt = 0; m_st = 2;
`endif
      end
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.cnt  = m_cnt;
    e.busy = (m_st == 1) ? 1 : 0;
    e.done = m_done;
    e.tc   = (m_cnt == 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    chk("count", 32'(count), 32'(e.cnt));
    chk("busy",  32'(busy),  32'(e.busy));
    chk("done",  32'(done),  32'(e.done));
    chk("tc",    32'(tc),    32'(e.tc));
    if (done === 1'b1) done_seen++;
  endtask

  // One clock: predict from current inputs, clock, compare 1 ns after the edge
  task automatic step();
    model_edge();
    push_model();
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic drive(input logic s, input int lv, input logic e, input logic c, input logic r);
    start = s; load_val = W'(lv); en = e; clear = c; reload_en = r;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done_seen = 0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();

    // Reset state, visible before any clock edge
    phase = "reset";
    #1 rst_n = 1'b0;
    #1;
    push_model();
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;

    // Plain count from 5
    phase = "cnt5";
    drive(1, 5, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0);
    repeat (7) step();

    // Enable held low twice at count 3
    phase = "hold";
    done_seen = 0;
    drive(1, 4, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    en = 1'b0; step(); step();
    en = 1'b1; repeat (4) step();
    chk("done_pulses", 32'(done_seen), 32'd1);

    // Zero load: immediate terminal event, never busy
    phase = "zero";
    drive(1, 0, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); step(); step();

    // Start ignored mid-count
    phase = "nostart";
    drive(1, 7, 1, 0, 0); step();
    drive(1, 3, 1, 0, 0); step(); step();
    drive(0, 0, 1, 0, 0); repeat (6) step();

    // Clear with simultaneous start at count 6, then a fresh count of 2
    phase = "clear";
    drive(1, 9, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); repeat (3) step();
    drive(1, 5, 1, 1, 0); step();
    drive(0, 0, 1, 0, 0); step();
    drive(1, 2, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); repeat (3) step();

    // Asynchronous reset mid-count at 9
    phase = "async_rst";
    drive(1, 12, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); repeat (3) step();
    chk("pre_count", 32'(count), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push_model();
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0); step();

    // Auto-reload (ignored when the option is compiled out)
    phase = "reload";
    done_seen = 0;
    drive(1, 3, 1, 0, 1); step();
    drive(0, 0, 1, 0, 1); repeat (9) step();
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    chk("reload_pulses", 32'(done_seen), 32'd3);
`else
    chk("reload_pulses", 32'(done_seen), 32'd1);
`endif
    reload_en = 1'b0; repeat (4) step();

    // Random traffic
    phase = "random";
    for (int i = 0; i < 120; i++) begin
      drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1) == 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_down_counter
`default_nettype wire
